// File: rtl/int_timer.sv
// int_timer: programmable periodic interrupt source for the clk_24mhz domain.
//
// Drives the int_24 level that the Z80 interrupt controller synchronises and
// edge-detects. The period and pulse length come from an active register set,
// which is reloaded from a shadow set only at period boundaries, or on any
// edge while the timer is disabled. Acknowledges from the Z80 domain are
// synchronised and edge-detected. Every period that starts while the previous
// interrupt is still unacknowledged is counted in 'missed'.
//
// Handshake note: cfg_wr and clr_missed are single-cycle strobes sampled on
// the rising clock edge. There is no ready/back-pressure: a strobe is always
// accepted on the edge at which it is sampled high. int_ack_a is an
// asynchronous level, and only its synchronised rising edge has any effect.

module int_timer #(
  parameter int unsigned DEF_PERIOD      = 640,
  parameter int unsigned DEF_LEN         = 100,
  parameter bit          SATURATE_MISSED = 1'b1
) (
  input  logic        clk_24mhz,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cfg_wr,
  input  logic [15:0] cfg_period,
  input  logic [15:0] cfg_len,
  input  logic        int_ack_a,
  input  logic        clr_missed,
  output logic        int_24,
  output logic        tick,
  output logic [7:0]  missed,
  output logic        cfg_pending
);

  localparam logic [15:0] DEF_PERIOD_W = 16'(DEF_PERIOD);
  localparam logic [15:0] DEF_LEN_W    = 16'(DEF_LEN);
  localparam logic [15:0] MIN_PERIOD   = 16'd2;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [15:0] r_ctr;          // position inside the current period
  logic        r_was_en;       // en as sampled on the previous edge
  logic        r_int;          // registered int_24
  logic        r_tick;         // registered tick
  logic [15:0] r_act_period;   // period currently in use
  logic [15:0] r_act_len;      // pulse length currently in use
  logic [15:0] r_sh_period;    // shadow period waiting to be applied
  logic [15:0] r_sh_len;       // shadow length waiting to be applied
  logic        r_pending;      // shadow holds a config not yet applied
  logic        r_s1;           // acknowledge synchroniser, first stage
  logic        r_s2;           // acknowledge synchroniser, second stage
  logic        r_s3;           // previous synchronised ack, for edge detect
  logic        r_outstanding;  // last interrupt not yet acknowledged
  logic [7:0]  r_missed;       // unacknowledged-period counter

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [15:0] w_eff_period;   // period clamped to the minimum of 2
  logic        w_last;         // counter sits on the final cycle of the period
  logic        w_wrap;         // next counter value is 0
  logic [15:0] w_nxt;          // next counter value while running
  logic        w_start;        // a new period starts on this edge
  logic        w_apply;        // shadow is copied to active on this edge
  logic [15:0] w_len_used;     // length that governs int_24 for the next cycle
  logic        w_ack_edge;     // synchronised rising edge of int_ack_a
  logic        w_missed_inc;   // a period starts with the last one unacknowledged
  logic [7:0]  w_missed_plus;  // missed + 1, saturating or wrapping
  logic [7:0]  w_missed_next;  // next value of the missed counter
  logic        w_out_next;     // next value of the outstanding flag

  // Clamp the programmed period so a period of 0 or 1 still gives a usable count.
  always_comb begin
    w_eff_period = r_act_period;
    if (r_act_period < MIN_PERIOD) begin
      w_eff_period = MIN_PERIOD;
    end
  end

  // Work out the next counter value and whether this edge begins a new period.
  always_comb begin
    w_last  = (r_ctr == (w_eff_period - 16'd1));
    w_wrap  = ~r_was_en | w_last;
    w_nxt   = w_wrap ? 16'd0 : (r_ctr + 16'd1);
    w_start = en & w_wrap;
  end

  // Shadow-to-active transfer happens at a period start, or on any disabled edge.
  always_comb begin
    w_apply    = r_pending & (~en | w_wrap);
    w_len_used = w_apply ? r_sh_len : r_act_len;
  end

  // Decide how the outstanding flag and the missed counter move on this edge.
  always_comb begin
    w_ack_edge    = r_s2 & ~r_s3;
    w_missed_inc  = w_start & r_outstanding & ~w_ack_edge;
    w_missed_plus = r_missed + 8'd1;
    if (SATURATE_MISSED && (r_missed == 8'hFF)) begin
      w_missed_plus = r_missed;
    end

    w_missed_next = r_missed;
    if (w_missed_inc) begin
      w_missed_next = w_missed_plus;
    end
    // A clear always wins over a simultaneous increment.
    if (clr_missed) begin
      w_missed_next = 8'd0;
    end

    w_out_next = r_outstanding;
    if (w_start) begin
      // A new interrupt is now outstanding, whether or not the previous one
      // was acknowledged on this same edge.
      w_out_next = 1'b1;
    end else if (w_ack_edge) begin
      w_out_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Bring the asynchronous acknowledge into clk_24mhz and keep one extra stage for the edge.
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= int_ack_a;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Period counter and the registered int_24/tick outputs.
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr    <= 16'd0;
      r_was_en <= 1'b0;
      r_int    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_was_en <= en;
      if (en) begin
        r_ctr  <= w_nxt;
        r_int  <= (w_nxt < w_len_used);
        r_tick <= w_wrap;
      end else begin
        r_ctr  <= 16'd0;
        r_int  <= 1'b0;
        r_tick <= 1'b0;
      end
    end
  end

  // Active configuration, reloaded from the shadow only when a transfer is due.
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_act_period <= DEF_PERIOD_W;
      r_act_len    <= DEF_LEN_W;
    end else if (w_apply) begin
      r_act_period <= r_sh_period;
      r_act_len    <= r_sh_len;
    end
  end

  // Shadow configuration and its pending flag; a write beats a same-edge transfer.
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_period <= DEF_PERIOD_W;
      r_sh_len    <= DEF_LEN_W;
      r_pending   <= 1'b0;
    end else begin
      if (cfg_wr) begin
        r_sh_period <= cfg_period;
        r_sh_len    <= cfg_len;
        r_pending   <= 1'b1;
      end else if (w_apply) begin
        r_pending   <= 1'b0;
      end
    end
  end

  // Outstanding-interrupt flag and the missed counter.
  always_ff @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= 1'b0;
      r_missed      <= 8'd0;
    end else begin
      r_outstanding <= w_out_next;
      r_missed      <= w_missed_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign int_24      = r_int;
  assign tick        = r_tick;
  assign missed      = r_missed;
  assign cfg_pending = r_pending;

endmodule

// File: tb/tb_int_timer.sv
// tb_int_timer: randomized and directed stimulus for int_timer, checked every
// cycle against a behavioural model of the timer's rules, plus literal
// expectations at known points of each scenario.

module tb_int_timer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_24mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        en        = 1'b0;
  logic        cfg_wr    = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_len    = '0;
  logic        int_ack_a  = 1'b0;
  logic        clr_missed = 1'b0;
  logic        int_24;
  logic        tick;
  logic [7:0]  missed;
  logic        cfg_pending;

  always #5 clk_24mhz = ~clk_24mhz;

  int_timer dut (
    .clk_24mhz  (clk_24mhz),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_wr     (cfg_wr),
    .cfg_period (cfg_period),
    .cfg_len    (cfg_len),
    .int_ack_a  (int_ack_a),
    .clr_missed (clr_missed),
    .int_24     (int_24),
    .tick       (tick),
    .missed     (missed),
    .cfg_pending(cfg_pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: position in period (-1 = idle), configs, ack history.
  // ---------------------------------------------------------------------------
  int m_pos, m_per, m_len, m_sh_per, m_sh_len, m_missed;
  bit m_pend, m_out, m_int, m_tick;
  bit ack_hist[$];   // [0] = ack seen one edge ago, [1] two edges ago, ...

  task automatic model_reset();
    m_pos = -1; m_per = 640; m_len = 100; m_sh_per = 640; m_sh_len = 100;
    m_missed = 0; m_pend = 0; m_out = 0; m_int = 0; m_tick = 0;
    ack_hist = '{0, 0, 0};
  endtask

  task automatic model_step();
    int p;
    bit start, ack_rise;
    // An acknowledge counts two edges after the input is first seen high.
    ack_rise = ack_hist[1] && !ack_hist[2];
    start = 0;
    if (!en) begin
      m_pos = -1; m_int = 0; m_tick = 0;
      if (m_pend) begin m_per = m_sh_per; m_len = m_sh_len; m_pend = 0; end
    end else begin
      p = (m_per < 2) ? 2 : m_per;
      start = (m_pos < 0) || (m_pos == p - 1);
      m_pos = start ? 0 : m_pos + 1;
      if (start && m_pend) begin m_per = m_sh_per; m_len = m_sh_len; m_pend = 0; end
      m_int  = (m_pos < m_len);
      m_tick = start;
    end
    if (start) begin
      if (m_out && !ack_rise && m_missed < 255) m_missed++;
      m_out = 1;
    end else if (ack_rise) begin
      m_out = 0;
    end
    if (clr_missed) m_missed = 0;
    if (cfg_wr) begin m_sh_per = cfg_period; m_sh_len = cfg_len; m_pend = 1; end
    ack_hist.push_front(int_ack_a);
    void'(ack_hist.pop_back());
  endtask

  always @(posedge clk_24mhz or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk_24mhz) begin
    if (rst_n) begin
      check("model_int_24", 32'(int_24), 32'(m_int));
      check("model_tick", 32'(tick), 32'(m_tick));
      check("model_missed", 32'(missed), 32'(m_missed));
      check("model_cfg_pending", 32'(cfg_pending), 32'(m_pend));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_24mhz);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0; clr_missed = 1'b0; int_ack_a = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  task automatic write_cfg(input logic [15:0] p, input logic [15:0] l);
    cfg_wr = 1'b1; cfg_period = p; cfg_len = l;
    step();
    cfg_wr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  int nt, highs;
  int tick_at[3];

  initial begin
    model_reset();

    // 1: default period/length after reset
    do_reset();
    check("reset_int_24", 32'(int_24), 0);
    check("reset_tick", 32'(tick), 0);
    check("reset_missed", 32'(missed), 0);
    check("reset_pending", 32'(cfg_pending), 0);
    en = 1'b1; nt = 0; highs = 0;
    for (int i = 0; i < 1300; i++) begin
      step();
      if (tick) begin if (nt < 3) tick_at[nt] = i; nt++; end
      if (int_24) highs++;
    end
    check("t1_tick_count", 32'(nt), 3);
    check("t1_tick0", 32'(tick_at[0]), 0);
    check("t1_tick1", 32'(tick_at[1]), 640);
    check("t1_tick2", 32'(tick_at[2]), 1280);
    check("t1_int_high_cycles", 32'(highs), 220);
    check("t1_missed", 32'(missed), 2);

    // 2: reconfigure mid-period, applied at the next wrap
    do_reset();
    en = 1'b1;
    steps(301);
    write_cfg(16'd200, 16'd10);
    check("t2_pending_set", 32'(cfg_pending), 1);
    steps(338);
    check("t2_pending_held", 32'(cfg_pending), 1);
    check("t2_no_early_tick", 32'(tick), 0);
    step();
    check("t2_wrap_tick", 32'(tick), 1);
    check("t2_wrap_pending", 32'(cfg_pending), 0);
    check("t2_wrap_int", 32'(int_24), 1);
    steps(9);
    check("t2_len_last", 32'(int_24), 1);
    step();
    check("t2_len_end", 32'(int_24), 0);
    steps(189);
    check("t2_gap_no_tick", 32'(tick), 0);
    step();
    check("t2_new_period_tick", 32'(tick), 1);

    // 3: period clamped to 2 with L=0, then L>=P
    do_reset();
    write_cfg(16'd1, 16'd0);
    check("t3_pending_dis", 32'(cfg_pending), 1);
    step();
    check("t3_applied_dis", 32'(cfg_pending), 0);
    en = 1'b1; nt = 0; highs = 0;
    for (int i = 0; i < 10; i++) begin
      step(); if (tick) nt++; if (int_24) highs++;
    end
    check("t3_p2_ticks", 32'(nt), 5);
    check("t3_l0_highs", 32'(highs), 0);
    write_cfg(16'd3, 16'd5);
    steps(4);
    nt = 0; highs = 0;
    for (int i = 0; i < 12; i++) begin
      step(); if (tick) nt++; if (int_24) highs++;
    end
    check("t3_p3_ticks", 32'(nt), 4);
    check("t3_stuck_high", 32'(highs), 12);

    // 4: missed counting, acknowledge, saturation
    do_reset();
    en = 1'b1;
    steps(1921);
    check("t4_missed3", 32'(missed), 3);
    steps(100);
    int_ack_a = 1'b1; steps(3); int_ack_a = 1'b0;
    steps(537);
    check("t4_tick_after_ack", 32'(tick), 1);
    check("t4_missed_unchanged", 32'(missed), 3);
    write_cfg(16'd2, 16'd1);
    steps(1250);
    check("t4_saturated", 32'(missed), 255);

    // 5: ack coinciding with tick; clear coinciding with increment
    do_reset();
    write_cfg(16'd10, 16'd3);
    step();
    en = 1'b1;
    steps(8);
    int_ack_a = 1'b1;
    steps(3);
    check("t5_coincide_tick", 32'(tick), 1);
    check("t5_coincide_missed", 32'(missed), 0);
    steps(2);
    int_ack_a = 1'b0;
    steps(8);
    check("t5_missed1", 32'(missed), 1);
    steps(10);
    check("t5_missed2", 32'(missed), 2);
    steps(9);
    clr_missed = 1'b1;
    step();
    clr_missed = 1'b0;
    check("t5_clr_tick", 32'(tick), 1);
    check("t5_clr_wins", 32'(missed), 0);

    // 6: disable mid-period, config while disabled, async reset mid-pulse
    do_reset();
    en = 1'b1;
    steps(51);
    en = 1'b0;
    step();
    check("t6_dis_int", 32'(int_24), 0);
    check("t6_dis_tick", 32'(tick), 0);
    write_cfg(16'd300, 16'd40);
    check("t6_pending", 32'(cfg_pending), 1);
    step();
    check("t6_applied", 32'(cfg_pending), 0);
    en = 1'b1;
    step();
    check("t6_reen_tick", 32'(tick), 1);
    check("t6_reen_int", 32'(int_24), 1);
    steps(39);
    check("t6_len_last", 32'(int_24), 1);
    step();
    check("t6_len_end", 32'(int_24), 0);
    steps(260);
    check("t6_wrap_tick", 32'(tick), 1);
    check("t6_pre_reset_missed", 32'(missed), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_int", 32'(int_24), 0);
    check("t6_async_tick", 32'(tick), 0);
    check("t6_async_missed", 32'(missed), 0);
    check("t6_async_pending", 32'(cfg_pending), 0);
    en = 1'b0;
    steps(2);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 19) != 0);
      cfg_wr     = ($urandom_range(0, 39) == 0);
      cfg_period = 16'($urandom_range(0, 12));
      cfg_len    = 16'($urandom_range(0, 14));
      clr_missed = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) int_ack_a = ~int_ack_a;
      step();
    end
    en = 1'b0; cfg_wr = 1'b0; clr_missed = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/int_timer.md
Name: int_timer

Overview:
Programmable periodic interrupt source in the clk_24mhz domain. It produces the int_24 level that the Z80 interrupt controller synchronises and edge-detects, replacing the fixed 640-cycle/100-cycle generator. Period and pulse length are programmable through a shadowed register set that takes effect only at period boundaries. The block also tracks acknowledge handshakes returned from the Z80 domain and counts interrupts that were never acknowledged.

Parameters:
DEF_PERIOD, 640, period in clk_24mhz cycles after reset (valid range 2..65535)
DEF_LEN, 100, int_24 high time in clk_24mhz cycles after reset
SATURATE_MISSED, 1, 1 = missed counter saturates at 255; 0 = missed counter wraps

Ports:
clk_24mhz  in  1  24 MHz system clock
rst_n  in  1  reset, asynchronous assert, active low
en  in  1  timer enable (level)
cfg_wr  in  1  one-cycle strobe that captures cfg_period and cfg_len into the shadow registers
cfg_period  in  16  new period in cycles
cfg_len  in  16  new pulse length in cycles
int_ack_a  in  1  acknowledge level from the Z80 domain (asynchronous); a rising edge acknowledges
clr_missed  in  1  one-cycle strobe that clears missed
int_24  out  1  interrupt request level to the interrupt controller
tick  out  1  one-cycle pulse at every period start
missed  out  8  count of periods that started while the previous interrupt was still unacknowledged
cfg_pending  out  1  shadow configuration is waiting to be applied

Behaviour:
- Reset (async, rst_n=0):
  - ctr=0; int_24=0; tick=0; missed=0; cfg_pending=0.
  - Active and shadow period = DEF_PERIOD; active and shadow length = DEF_LEN.
  - outstanding=0; both synchroniser flops and the edge-detect register = 0.
- Effective period: P = max(active_period, 2). Effective length: L = active_len.
- Disabled (en=0):
  - ctr<=0, int_24<=0, tick<=0.
  - A pending shadow configuration is copied to the active registers on the next edge, and cfg_pending<=0.
- Running (en=1). Compute nxt:
  - nxt=0 if the previous cycle was disabled or ctr==P-1;
  - otherwise nxt=ctr+1.
  - On each edge: ctr<=nxt; int_24<=(nxt<L); tick<=(nxt==0).
  - Latency: int_24 and tick rise on the first edge at which en is sampled 1.
- Length boundaries:
  - L=0: int_24 stays 0, but tick is still generated.
  - L>=P: int_24 stays 1 continuously while enabled.
- Config write: cfg_wr=1 loads the shadow registers and sets cfg_pending<=1. A second write before the config is applied overwrites the shadow (last write wins).
- Config apply while running: when nxt==0 is computed with cfg_pending=1, the shadow is copied to active on that same edge, and the new P/L are used from the following cycle onward.
  - The int_24 value for the nxt=0 cycle uses the new L.
  - cfg_wr and apply on the same edge: the shadow takes the new value, the apply uses the old shadow, and cfg_pending stays 1.
- Acknowledge path:
  - int_ack_a goes through a 2-flop synchroniser s1→s2, then s3<=s2.
  - ack_edge = s2 & ~s3.
- Outstanding tracking, evaluated on every edge where tick would be set (nxt==0 while running):
  - If outstanding=1 and there is no ack_edge, missed increments (saturating or wrapping per SATURATE_MISSED).
  - outstanding<=1 in all cases.
  - ack_edge with no period start: outstanding<=0.
  - ack_edge on the same edge as a period start: counts as acknowledging the previous interrupt, so missed is unchanged and outstanding<=1.
- clr_missed: missed<=0. If a clear coincides with an increment, the result is 0.
- Disable mid-period: the counter aborts immediately, int_24 drops on the next edge, and outstanding and missed keep their values. Re-enabling starts a fresh period at ctr=0.
- Reset mid-period: all state returns immediately (asynchronously) to reset values; the shadow configuration is lost.

Test Plan:
1. Reset, then en=1 and run 1300 cycles → tick at cycles 0, 640, 1280; int_24 high for exactly 100 cycles after each tick; period 640 cycles.
2. While running at ctr=300, cfg_wr with period=200, len=10 → cfg_pending=1 until the next wrap; the old 640/100 finishes; then ticks every 200 cycles with int_24 high for 10; cfg_pending=0.
3. cfg_period=1, cfg_len=0 → P=2: tick every 2 cycles, int_24 always 0. Then cfg_len=5 with period=3 → int_24 stuck at 1.
4. Never pulse int_ack_a for 4 periods → missed=3. Then pulse int_ack_a (held 3 cycles) between ticks → the next period adds nothing. Run 300 unacknowledged periods with SATURATE_MISSED=1 → missed=255.
5. Make an ack_edge coincide with a tick → missed unchanged. clr_missed coinciding with an increment → missed=0.
6. Drop en at ctr=50 → int_24=0 on the next edge, ctr=0. A cfg_wr while disabled is applied on the next edge. Re-enable → tick on the first edge. Assert rst_n=0 mid-pulse → int_24=0 immediately (no clock required).
